travel_animator: RTL and testbench
==================================

Name: travel_animator

Overview:
Consumes the 3-bit travel code from the transaction controller and animates a 4x4 "packet" sprite along the on-screen path for that leg, between two node positions. It emits per-pixel plot requests to the VGA adapter. When the sprite reaches the destination node it returns a one-cycle done_travel pulse, which advances the controller to its next step.

Parameters:
X_W, 8, pixel x-coordinate width
Y_W, 7, pixel y-coordinate width
TICK_DIV, 833333, clock cycles the sprite waits between moves (60 Hz at 50 MHz); must be >= 1
NODE_X, {8'd140,8'd110,8'd80,8'd50,8'd20}, packed x of nodes N4..N0 (N0 in LSBs); every value <= 2^X_W-4
NODE_Y, {7'd20,7'd20,7'd20,7'd20,7'd20}, packed y of nodes N4..N0; every value <= 2^Y_W-4
SPRITE_COLOUR, 3'b110, colour used to draw the sprite
BG_COLOUR, 3'b000, colour used to erase the sprite

Ports:
clock  in  1  system clock, all state on posedge
resetn  in  1  asynchronous active-low reset
travel  in  3  leg code from controller: 001 leg1 N0->N1, 010 leg2 N1->N2, 011 leg3 N2->N3, 101 leg4 N3->N4; 000 and all other codes mean no travel
done_travel  out  1  one-cycle pulse when the sprite has arrived
plot  out  1  pixel write strobe to VGA adapter
x  out  X_W  pixel x for plot
y  out  Y_W  pixel y for plot
colour  out  3  pixel colour for plot
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: asynchronous, active-low. The block enters IDLE. done_travel, plot, busy and all counters go to 0; x, y and colour go to 0. Reset mid-animation leaves the partial sprite on screen; no erase is performed.
- Registers: cur_x/cur_y (sprite top-left), tgt_x/tgt_y, pixel counter pix[3:0] (col = pix[1:0], row = pix[3:2]), tick counter of width clog2(TICK_DIV).
- IDLE: if travel is a valid code, go to LOAD on that edge; otherwise stay. Invalid codes (100, 110, 111) never start an animation.
- LOAD (1 cycle): cur = source node, tgt = destination node, pix = 0. The leg is latched here; later changes to travel are ignored until HOLD. Next state is DRAW.
- DRAW (16 cycles): plot = 1, colour = SPRITE_COLOUR, x = cur_x + col, y = cur_y + row; pix increments each cycle. After pix = 15: if cur == tgt go to DONE, else go to WAIT with tick = 0.
- WAIT (TICK_DIV cycles): plot = 0; tick counts 0..TICK_DIV-1, then go to ERASE with pix = 0.
- ERASE (16 cycles): same pixel sweep as DRAW with colour = BG_COLOUR; then go to MOVE.
- MOVE (1 cycle): each axis independently steps +1 or -1 toward its target, or holds if already equal, so diagonal moves occur when both axes differ. Next state is DRAW with pix = 0.
- DONE (1 cycle): done_travel = 1; next state is HOLD.
- HOLD: waits until travel == 000, then returns to IDLE. A code still held after done_travel cannot retrigger.
- Outputs are registered or decoded from state; plot is 0 outside DRAW/ERASE.
- Latency: with D = max(|dx|, |dy|), done_travel is high exactly 17 + D*(TICK_DIV+33) cycles after the edge that samples the valid code in IDLE. For D = 0, only one DRAW pass occurs.
- Coordinate adds truncate to X_W/Y_W; the NODE limits above guarantee no wrap.

Test Plan:
- TICK_DIV=4, N0=(10,10), N1=(13,10); travel=001 held -> 16 DRAW plots at x 10..13, y 10..13. done_travel pulses exactly 17+3*37=128 cycles after the IDLE sample. Final DRAW covers x 13..16, y 10..13. Exactly 4 DRAW and 3 ERASE sweeps occur.
- N1=(13,10), N2=(11,13); travel=010 -> cur goes (12,11), (11,12), (11,13). done_travel arrives at 128 cycles.
- travel=101, N3=N4=(50,20) -> single DRAW sweep, done_travel at cycle 17, no ERASE.
- travel=100 held for 1000 cycles -> plot, busy and done_travel stay 0.
- After done, travel held at 001 for 200 cycles -> no further plot and no second done_travel. Then travel=000 -> busy falls the next cycle. Then travel=010 -> a new animation starts.
- resetn pulsed low mid-WAIT (asynchronously, between edges) -> plot, busy and done_travel are 0 immediately. After release, the block is in IDLE and restarts cleanly on travel=001.

Source files
------------

// File: rtl/travel_animator.sv
// Animates a 4x4 sprite between two path nodes for the selected travel leg,
// issuing one pixel write per cycle while drawing or erasing.
//
// state | meaning
// IDLE  | waiting for a valid travel code
// LOAD  | latch source/target node coordinates
// DRAW  | 16-pixel sweep in sprite colour
// WAIT  | frame delay of TICK_DIV cycles
// ERASE | 16-pixel sweep in background colour
// MOVE  | step each axis one pixel toward target
// DONE  | one-cycle done_travel pulse
// HOLD  | wait for travel to return to 000
module travel_animator #(
    parameter int              X_W           = 8,
    parameter int              Y_W           = 7,
    parameter int              TICK_DIV      = 833333,
    parameter logic [5*X_W-1:0] NODE_X       = {8'd140, 8'd110, 8'd80, 8'd50, 8'd20},
    parameter logic [5*Y_W-1:0] NODE_Y       = {7'd20, 7'd20, 7'd20, 7'd20, 7'd20},
    parameter logic [2:0]      SPRITE_COLOUR = 3'b110,
    parameter logic [2:0]      BG_COLOUR     = 3'b000
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic [2:0]     travel,
    output logic           done_travel,
    output logic           plot,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [2:0]     colour,
    output logic           busy
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DRAW, S_WAIT, S_ERASE, S_MOVE, S_DONE, S_HOLD
    } state_t;

    state_t state, state_nxt;

    logic [1:0]        leg;
    logic [X_W-1:0]    cur_x, tgt_x;
    logic [Y_W-1:0]    cur_y, tgt_y;
    logic [3:0]        pix;
    logic [TICK_W-1:0] tick;

    logic       code_ok;
    logic [1:0] code_leg;
    logic [2:0] src_i, dst_i;
    logic       at_tgt;

    always_comb begin
        code_ok  = 1'b1;
        code_leg = 2'd0;
        case (travel)
            3'b001:  code_leg = 2'd0;
            3'b010:  code_leg = 2'd1;
            3'b011:  code_leg = 2'd2;
            3'b101:  code_leg = 2'd3;
            default: code_ok  = 1'b0;
        endcase
    end

    // Leg n runs from node n to node n+1.
    assign src_i  = {1'b0, leg};
    assign dst_i  = src_i + 3'd1;
    assign at_tgt = (cur_x == tgt_x) && (cur_y == tgt_y);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (code_ok) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_DRAW;
            S_DRAW:  if (pix == 4'd15) state_nxt = at_tgt ? S_DONE : S_WAIT;
            S_WAIT:  if (tick == TICK_LAST) state_nxt = S_ERASE;
            S_ERASE: if (pix == 4'd15) state_nxt = S_MOVE;
            S_MOVE:  state_nxt = S_DRAW;
            S_DONE:  state_nxt = S_HOLD;
            S_HOLD:  if (travel == 3'b000) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            leg   <= '0;
            cur_x <= '0;
            cur_y <= '0;
            tgt_x <= '0;
            tgt_y <= '0;
            pix   <= '0;
            tick  <= '0;
        end else begin
            case (state)
                S_IDLE: if (code_ok) leg <= code_leg;
                S_LOAD: begin
                    cur_x <= NODE_X[int'(src_i)*X_W +: X_W];
                    cur_y <= NODE_Y[int'(src_i)*Y_W +: Y_W];
                    tgt_x <= NODE_X[int'(dst_i)*X_W +: X_W];
                    tgt_y <= NODE_Y[int'(dst_i)*Y_W +: Y_W];
                    pix   <= '0;
                end
                // pix wraps 15 -> 0, so the next sweep always starts clean.
                S_DRAW: begin
                    pix  <= pix + 4'd1;
                    tick <= '0;
                end
                S_WAIT: begin
                    tick <= tick + TICK_W'(1);
                    pix  <= '0;
                end
                S_ERASE: pix <= pix + 4'd1;
                S_MOVE: begin
                    if (cur_x < tgt_x)      cur_x <= cur_x + X_W'(1);
                    else if (cur_x > tgt_x) cur_x <= cur_x - X_W'(1);
                    if (cur_y < tgt_y)      cur_y <= cur_y + Y_W'(1);
                    else if (cur_y > tgt_y) cur_y <= cur_y - Y_W'(1);
                    pix <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        plot        = 1'b0;
        colour      = 3'b000;
        x           = '0;
        y           = '0;
        done_travel = (state == S_DONE);
        busy        = (state != S_IDLE);
        if (state == S_DRAW || state == S_ERASE) begin
            plot   = 1'b1;
            colour = (state == S_DRAW) ? SPRITE_COLOUR : BG_COLOUR;
            x      = cur_x + X_W'(pix[1:0]);
            y      = cur_y + Y_W'(pix[3:2]);
        end
    end

endmodule

// File: tb/tb_travel_animator.sv
// Randomized directed bench for travel_animator; expected pixel streams and
// arrival times come from a path model built from node coordinates.
module tb_travel_animator;

    localparam int TICK = 4;
    localparam logic [39:0] NX = {8'd50, 8'd50, 8'd11, 8'd13, 8'd10};
    localparam logic [34:0] NY = {7'd20, 7'd20, 7'd13, 7'd10, 7'd10};

    int node_x[5] = '{10, 13, 11, 50, 50};
    int node_y[5] = '{10, 10, 13, 20, 20};
    logic [2:0] codes[4] = '{3'b001, 3'b010, 3'b011, 3'b101};
    logic [2:0] bad_codes[4] = '{3'b000, 3'b100, 3'b110, 3'b111};

    logic       clock;
    logic       resetn;
    logic [2:0] travel;
    logic       done_travel;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [17:0] exp_q[$];

    travel_animator #(
        .X_W(8), .Y_W(7), .TICK_DIV(TICK),
        .NODE_X(NX), .NODE_Y(NY),
        .SPRITE_COLOUR(3'b110), .BG_COLOUR(3'b000)
    ) dut (
        .clock(clock), .resetn(resetn), .travel(travel),
        .done_travel(done_travel), .plot(plot), .x(x), .y(y),
        .colour(colour), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input int px, input int py, input logic [2:0] c);
        for (int p = 0; p < 16; p++)
            exp_q.push_back({8'(px + p % 4), 7'(py + p / 4), c});
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic run_leg(input int leg, input bit garbage);
        int sx, sy, tx, ty, px, py, d, exp_done;
        bit seen;
        logic [17:0] e;
        sx = node_x[leg];     sy = node_y[leg];
        tx = node_x[leg + 1]; ty = node_y[leg + 1];
        exp_q.delete();
        px = sx; py = sy;
        forever begin
            sweep(px, py, 3'b110);
            if (px == tx && py == ty) break;
            sweep(px, py, 3'b000);
            if (tx > px) px++; else if (tx < px) px--;
            if (ty > py) py++; else if (ty < py) py--;
        end
        d = ((tx > sx) ? tx - sx : sx - tx);
        if (((ty > sy) ? ty - sy : sy - ty) > d) d = (ty > sy) ? ty - sy : sy - ty;
        exp_done = 17 + d * (TICK + 33);

        travel = codes[leg];
        cyc();
        seen = 1'b0;
        for (int c = 1; c <= exp_done + 40; c++) begin
            cyc();
            if (garbage && c >= 2 && $urandom_range(0, 7) == 0)
                travel = 3'($urandom_range(0, 7));
            if (plot) begin
                if (exp_q.size() == 0) chk("extra_plot", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("pixel", {14'd0, x, y, colour}, {14'd0, e});
                end
            end
            if (done_travel) begin
                chk("done_cycle", c, exp_done);
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", seen, 1);
        chk("pixels_left", exp_q.size(), 0);
        cyc();
        chk("done_pulse", done_travel, 0);
        chk("busy_hold", busy, 1);
    endtask

    task automatic release_leg();
        travel = 3'b000;
        cyc();
        chk("busy_fall", busy, 0);
    endtask

    initial begin
        bit act, bz;
        int leg;
        resetn = 1'b0;
        travel = 3'b000;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_done", done_travel, 0);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_xyc", {x, y, colour}, 0);
        resetn = 1'b1;
        cyc();

        act = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            travel = bad_codes[$urandom_range(1, 3)];
            cyc();
            act |= plot | busy | done_travel;
        end
        chk("invalid_idle", act, 0);
        travel = 3'b000;
        cyc();

        run_leg(0, 1'b0);
        travel = 3'b001;
        act = 1'b0; bz = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cyc();
            act |= plot | done_travel;
            bz &= busy;
        end
        chk("hold_quiet", act, 0);
        chk("hold_busy", bz, 1);
        release_leg();

        run_leg(1, 1'b0); release_leg();
        run_leg(3, 1'b0); release_leg();
        run_leg(2, 1'b1); release_leg();

        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 4)) begin
                travel = bad_codes[$urandom_range(0, 3)];
                cyc();
            end
            leg = $urandom_range(0, 3);
            run_leg(leg, 1'b1);
            release_leg();
        end

        // Asynchronous reset during the inter-frame wait.
        travel = 3'b001;
        cyc();
        repeat (18) cyc();
        chk("wait_busy", busy, 1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_plot", plot, 0);
        chk("arst_done", done_travel, 0);
        travel = 3'b000;
        #1 resetn = 1'b1;
        cyc();
        chk("post_rst_idle", busy, 0);

        // Asynchronous reset in the middle of a draw sweep.
        travel = 3'b001;
        cyc();
        repeat (5) cyc();
        chk("draw_plot", plot, 1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_draw_plot", plot, 0);
        chk("arst_draw_col", {x, y, colour}, 0);
        travel = 3'b000;
        #1 resetn = 1'b1;
        cyc();
        run_leg(0, 1'b0);
        release_leg();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
